// File: rtl/reg_file_cmd_ctrl_if.sv
// Command controller bus: RX byte stream, register file port,
// TX handshake and error reporting.
interface reg_file_cmd_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_VLD;
  logic [DATA_W-1:0] RdData;
  logic              RdData_Valid;
  logic              TX_Busy;
  logic              WrEn;
  logic              RdEn;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WrData;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              TX_D_VLD;
  logic              ctrl_busy;
  logic              err_vld;
  logic [1:0]        err_code;

  modport master (
    output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD,
    input  ctrl_busy, err_vld, err_code
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
    output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD,
    output ctrl_busy, err_vld, err_code
  );
endinterface

// File: rtl/reg_file_cmd_ctrl.sv
// Frame decoder that turns RX bytes into register file
// write/read strobes and forwards read data to TX.
module reg_file_cmd_ctrl #(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 4,
  parameter int                DEPTH    = 16,
  parameter logic [DATA_W-1:0] WR_CMD   = 8'hAA,
  parameter logic [DATA_W-1:0] RD_CMD   = 8'hBB,
  parameter int                FRAME_TO = 255,
  parameter int                RD_TO    = 15
) (
  input logic               CLK,
  input logic               RST,
  reg_file_cmd_ctrl_if.slave bus
);

  localparam int TO_MAX = (FRAME_TO > RD_TO) ? FRAME_TO : RD_TO;
  localparam int CNT_W  = $clog2(TO_MAX + 1);

  localparam logic [1:0] ERR_OP    = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_TO    = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_WAIT
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] rdata_q, rdata_n;
  logic [ADDR_W-1:0] address_q, address_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [DATA_W-1:0] txdata_q, txdata_n;
  logic              wr_en_q, wr_en_n;
  logic              rd_en_q, rd_en_n;
  logic              tx_vld_q, tx_vld_n;
  logic              err_vld_q, err_vld_n;
  logic [1:0]        err_code_q, err_code_n;

  logic is_wr;
  logic is_rd;
  logic in_range;
  logic in_frame;
  logic frame_to;
  logic rd_to;

  assign is_wr    = (bus.RX_P_DATA == WR_CMD);
  assign is_rd    = (bus.RX_P_DATA == RD_CMD);
  // Range check uses the whole byte, not just the address bits
  assign in_range = (bus.RX_P_DATA < DATA_W'(DEPTH));
  assign in_frame = (state == WR_ADDR) ||
                    (state == WR_DATA) ||
                    (state == RD_ADDR);
  assign frame_to = (cnt == CNT_W'(FRAME_TO - 1));
  assign rd_to    = (cnt == CNT_W'(RD_TO - 1));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    rdata_n    = rdata_q;
    address_n  = address_q;
    wdata_n    = wdata_q;
    txdata_n   = txdata_q;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    tx_vld_n   = 1'b0;
    err_vld_n  = 1'b0;
    err_code_n = err_code_q;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.RX_D_VLD) begin
          unique case (1'b1)
            is_wr: state_n = WR_ADDR;
            is_rd: state_n = RD_ADDR;
            default: begin
              err_vld_n  = 1'b1;
              err_code_n = ERR_OP;
            end
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          cnt_n = '0;
          if (in_range) begin
            addr_n  = bus.RX_P_DATA[ADDR_W-1:0];
            state_n = WR_DATA;
          end else begin
            err_vld_n  = 1'b1;
            err_code_n = ERR_RANGE;
            state_n    = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          cnt_n     = '0;
          wr_en_n   = 1'b1;
          address_n = addr_q;
          wdata_n   = bus.RX_P_DATA;
          state_n   = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          cnt_n = '0;
          if (in_range) begin
            rd_en_n   = 1'b1;
            address_n = bus.RX_P_DATA[ADDR_W-1:0];
            state_n   = RD_WAIT;
          end else begin
            err_vld_n  = 1'b1;
            err_code_n = ERR_RANGE;
            state_n    = IDLE;
          end
        end
      end
      RD_WAIT: begin
        if (bus.RdData_Valid) begin
          rdata_n = bus.RdData;
          cnt_n   = '0;
          state_n = TX_WAIT;
        end else if (rd_to) begin
          err_vld_n  = 1'b1;
          err_code_n = ERR_TO;
          cnt_n      = '0;
          state_n    = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TX_WAIT: begin
        if (!bus.TX_Busy) begin
          tx_vld_n = 1'b1;
          txdata_n = rdata_q;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Inter-byte silence inside a frame
    if (in_frame && !bus.RX_D_VLD) begin
      if (frame_to) begin
        err_vld_n  = 1'b1;
        err_code_n = ERR_TO;
        cnt_n      = '0;
        state_n    = IDLE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      rdata_q    <= '0;
      address_q  <= '0;
      wdata_q    <= '0;
      txdata_q   <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      tx_vld_q   <= 1'b0;
      err_vld_q  <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      addr_q     <= addr_n;
      rdata_q    <= rdata_n;
      address_q  <= address_n;
      wdata_q    <= wdata_n;
      txdata_q   <= txdata_n;
      wr_en_q    <= wr_en_n;
      rd_en_q    <= rd_en_n;
      tx_vld_q   <= tx_vld_n;
      err_vld_q  <= err_vld_n;
      err_code_q <= err_code_n;
    end
  end

  assign bus.WrEn      = wr_en_q;
  assign bus.RdEn      = rd_en_q;
  assign bus.Address   = address_q;
  assign bus.WrData    = wdata_q;
  assign bus.TX_P_DATA = txdata_q;
  assign bus.TX_D_VLD  = tx_vld_q;
  assign bus.ctrl_busy = (state != IDLE);
  assign bus.err_vld   = err_vld_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Randomized bench for reg_file_cmd_ctrl with an emulated
// register file and an event-level frame model.
module tb_reg_file_cmd_ctrl;

  localparam int FRAME_TO = 255;
  localparam int RD_TO    = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_cmd_ctrl_if bus ();

  reg_file_cmd_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t wr_q[$];
  ev_t rd_q[$];
  ev_t tx_q[$];
  ev_t err_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int busy_cnt = 0;

  logic [7:0] exp_regs[16];
  logic [7:0] rf_mem[16];
  int         rd_delay = 1;
  int         rd_pend = 0;
  logic [3:0] rd_addr = '0;

  always @(posedge clk) cyc++;

  // Event recorder
  always @(posedge clk) begin
    #1;
    if (bus.WrEn) wr_q.push_back('{cyc, {4'h0, bus.Address}, bus.WrData});
    if (bus.RdEn) rd_q.push_back('{cyc, {4'h0, bus.Address}, 8'h00});
    if (bus.TX_D_VLD) tx_q.push_back('{cyc, 8'h00, bus.TX_P_DATA});
    if (bus.err_vld) err_q.push_back('{cyc, {6'h0, bus.err_code}, 8'h00});
    if (bus.ctrl_busy) busy_cnt++;
    if (bus.WrEn && bus.RdEn) viol++;
    if (bus.err_vld && (bus.WrEn || bus.RdEn || bus.TX_D_VLD)) viol++;
  end

  // Register file emulation
  always @(negedge clk) begin
    bus.RdData_Valid = 1'b0;
    if (bus.WrEn) rf_mem[bus.Address] = bus.WrData;
    if (rd_pend > 0) begin
      rd_pend--;
      if (rd_pend == 0) begin
        bus.RdData       = rf_mem[rd_addr];
        bus.RdData_Valid = 1'b1;
      end
    end
    if (bus.RdEn && rd_delay > 0) begin
      rd_pend = rd_delay;
      rd_addr = bus.Address;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic clear_q();
    wr_q.delete();
    rd_q.delete();
    tx_q.delete();
    err_q.delete();
    busy_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap,
                           output int sc);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    sc = cyc;
    @(negedge clk);
    bus.RX_D_VLD = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    while (bus.ctrl_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL settle ctrl_busy stuck after %0d cycles", n);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.err_vld} !== 4'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b exp 0000",
               {bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.err_vld});
    end
    checks++;
    if (bus.ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b exp 0", bus.ctrl_busy);
    end
    checks++;
    if ({bus.Address, bus.WrData, bus.TX_P_DATA} !== 20'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0 0 0",
               bus.Address, bus.WrData, bus.TX_P_DATA);
    end
    checks++;
    if (bus.err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset_err_code got %b exp 00", bus.err_code);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int s;
    int r;
    clear_q();
    rd_delay = 2;
    send_byte(8'hAA, 2, s);
    send_byte(8'h05, 2, s);
    send_byte(8'h3C, 2, s);
    settle();
    checks++;
    if (wr_q.size() != 1 || err_q.size() != 0) begin
      errors++;
      $display("FAIL write_count got wr=%0d err=%0d exp 1 0",
               wr_q.size(), err_q.size());
    end else if (wr_q[0].cyc != s + 1 || wr_q[0].a !== 8'h05 ||
                 wr_q[0].d !== 8'h3C) begin
      errors++;
      $display("FAIL write_ev got cyc=%0d a=%h d=%h exp %0d 05 3c",
               wr_q[0].cyc, wr_q[0].a, wr_q[0].d, s + 1);
    end
    exp_regs[5] = 8'h3C;

    clear_q();
    send_byte(8'hBB, 2, s);
    send_byte(8'h05, 2, s);
    settle();
    r = s + 1;
    checks++;
    if (rd_q.size() != 1 || rd_q[0].cyc != r || rd_q[0].a !== 8'h05) begin
      errors++;
      $display("FAIL read_ev got n=%0d exp n=1 cyc=%0d a=05",
               rd_q.size(), r);
    end
    checks++;
    if (tx_q.size() != 1 || tx_q[0].cyc != r + rd_delay + 2 ||
        tx_q[0].d !== exp_regs[5]) begin
      errors++;
      $display("FAIL read_tx got n=%0d exp n=1 cyc=%0d d=%h",
               tx_q.size(), r + rd_delay + 2, exp_regs[5]);
    end
  endtask

  task automatic test_bad_opcode_range();
    int s;
    clear_q();
    send_byte(8'h12, 3, s);
    checks++;
    if (err_q.size() != 1 || err_q[0].a !== 8'd1 ||
        err_q[0].cyc != s + 1 || busy_cnt != 0) begin
      errors++;
      $display("FAIL bad_op got n=%0d busy=%0d exp n=1 code=1 busy=0",
               err_q.size(), busy_cnt);
    end

    clear_q();
    send_byte(8'hAA, 1, s);
    send_byte(8'h10, 1, s);
    settle();
    checks++;
    if (err_q.size() != 1 || err_q[0].a !== 8'd2 ||
        err_q[0].cyc != s + 1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL range got err=%0d wr=%0d exp 1 code=2 wr=0",
               err_q.size(), wr_q.size());
    end

    clear_q();
    send_byte(8'hAA, 1, s);
    send_byte(8'h0F, 1, s);
    send_byte(8'hFF, 1, s);
    settle();
    checks++;
    if (wr_q.size() != 1 || wr_q[0].a !== 8'h0F ||
        wr_q[0].d !== 8'hFF || err_q.size() != 0) begin
      errors++;
      $display("FAIL wr15 got wr=%0d err=%0d exp wr=1 0f/ff err=0",
               wr_q.size(), err_q.size());
    end
    exp_regs[15] = 8'hFF;
    checks++;
    if (bus.err_code !== 2'b10) begin
      errors++;
      $display("FAIL err_hold got %b exp 10", bus.err_code);
    end
  endtask

  task automatic test_backpressure();
    int         s;
    int         bad = 0;
    int         tb;
    logic [7:0] v;
    v = 8'($urandom);
    clear_q();
    send_byte(8'hAA, 1, s);
    send_byte(8'h02, 1, s);
    send_byte(v, 1, s);
    settle();
    exp_regs[2] = v;

    clear_q();
    rd_delay = 1;
    bus.TX_Busy = 1'b1;
    send_byte(8'hBB, 1, s);
    send_byte(8'h02, 3, s);
    send_byte(8'h55, 0, s);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.ctrl_busy || bus.TX_D_VLD) bad++;
    end
    checks++;
    if (bad != 0 || tx_q.size() != 0) begin
      errors++;
      $display("FAIL bp_hold got bad=%0d tx=%0d exp 0 0",
               bad, tx_q.size());
    end
    tb = cyc;
    bus.TX_Busy = 1'b0;
    settle();
    checks++;
    if (tx_q.size() != 1 || tx_q[0].cyc != tb + 1 ||
        tx_q[0].d !== v) begin
      errors++;
      $display("FAIL bp_release got n=%0d exp n=1 cyc=%0d d=%h",
               tx_q.size(), tb + 1, v);
    end
    checks++;
    if (err_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 1) begin
      errors++;
      $display("FAIL bp_drop got err=%0d wr=%0d rd=%0d exp 0 0 1",
               err_q.size(), wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 40; it++) begin
      int         k;
      int         gap;
      int         s;
      int         ew;
      int         er;
      int         et;
      int         ee;
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] ecode;
      logic [7:0] td;
      logic       ok;
      k     = $urandom_range(0, 4);
      gap   = $urandom_range(0, 3);
      d     = 8'($urandom);
      a     = 8'($urandom_range(0, 15));
      ew    = 0;
      er    = 0;
      et    = 0;
      ee    = 0;
      ecode = 8'd0;
      td    = 8'h00;
      rd_delay = $urandom_range(1, 5);
      clear_q();
      if (k <= 1) begin
        send_byte(8'hAA, gap, s);
        send_byte(a, gap, s);
        send_byte(d, gap, s);
        ew = 1;
      end else if (k == 2) begin
        send_byte(8'hBB, gap, s);
        send_byte(a, gap, s);
        er = 1;
        et = 1;
        td = exp_regs[a[3:0]];
      end else if (k == 3) begin
        op = 8'($urandom);
        while (op == 8'hAA || op == 8'hBB) op = 8'($urandom);
        send_byte(op, gap, s);
        ee = 1;
        ecode = 8'd1;
      end else begin
        a = 8'($urandom_range(16, 255));
        send_byte($urandom_range(0, 1) ? 8'hAA : 8'hBB, gap, s);
        send_byte(a, gap, s);
        ee = 1;
        ecode = 8'd2;
      end
      settle();
      ok = (wr_q.size() == ew) && (rd_q.size() == er) &&
           (tx_q.size() == et) && (err_q.size() == ee);
      if (ok && ew == 1)
        ok = (wr_q[0].cyc == s + 1) && (wr_q[0].a === a) &&
             (wr_q[0].d === d);
      if (ok && er == 1)
        ok = (rd_q[0].cyc == s + 1) && (rd_q[0].a === a) &&
             (tx_q[0].d === td) &&
             (tx_q[0].cyc == s + 1 + rd_delay + 2);
      if (ok && ee == 1)
        ok = (err_q[0].cyc == s + 1) && (err_q[0].a === ecode);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_%0d kind=%0d got wr=%0d rd=%0d tx=%0d err=%0d exp %0d %0d %0d %0d a=%h d=%h",
                 it, k, wr_q.size(), rd_q.size(), tx_q.size(),
                 err_q.size(), ew, er, et, ee, a, d);
      end
      if (ew == 1) exp_regs[a[3:0]] = d;
    end
  endtask

  task automatic test_timeouts();
    int         s;
    int         n;
    logic [7:0] v;
    clear_q();
    send_byte(8'hAA, 0, s);
    n = 0;
    while (err_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err_q.size() != 1 || err_q[0].a !== 8'd3 ||
        err_q[0].cyc != s + FRAME_TO + 1 || bus.ctrl_busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_to got n=%0d cyc=%0d exp n=1 code=3 cyc=%0d",
               err_q.size(), err_q.size() ? err_q[0].cyc : -1,
               s + FRAME_TO + 1);
    end

    v = 8'($urandom);
    clear_q();
    send_byte(8'hAA, FRAME_TO - 1, s);
    send_byte(8'h03, FRAME_TO - 1, s);
    send_byte(v, 2, s);
    settle();
    checks++;
    if (wr_q.size() != 1 || err_q.size() != 0 || wr_q[0].cyc != s + 1 ||
        wr_q[0].a !== 8'h03 || wr_q[0].d !== v) begin
      errors++;
      $display("FAIL frame_edge got wr=%0d err=%0d exp wr=1 err=0",
               wr_q.size(), err_q.size());
    end
    exp_regs[3] = v;

    clear_q();
    rd_delay = 0;
    send_byte(8'hBB, 1, s);
    send_byte(8'h07, 0, s);
    settle();
    checks++;
    if (rd_q.size() != 1 || err_q.size() != 1 || tx_q.size() != 0 ||
        err_q[0].a !== 8'd3 || err_q[0].cyc != s + 1 + RD_TO) begin
      errors++;
      $display("FAIL rd_to got rd=%0d err=%0d tx=%0d exp 1 1 0 cyc=%0d",
               rd_q.size(), err_q.size(), tx_q.size(), s + 1 + RD_TO);
    end

    clear_q();
    rd_delay = RD_TO - 1;
    send_byte(8'hBB, 1, s);
    send_byte(8'h07, 0, s);
    settle();
    checks++;
    if (tx_q.size() != 1 || err_q.size() != 0 ||
        tx_q[0].d !== exp_regs[7]) begin
      errors++;
      $display("FAIL rd_edge got tx=%0d err=%0d exp tx=1 d=%h err=0",
               tx_q.size(), err_q.size(), exp_regs[7]);
    end
    rd_delay = 1;
  endtask

  task automatic test_reset_midframe();
    int s;
    clear_q();
    send_byte(8'hAA, 1, s);
    send_byte(8'h03, 1, s);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.WrEn, bus.RdEn, bus.TX_D_VLD, bus.err_vld,
         bus.ctrl_busy, bus.err_code, bus.Address,
         bus.WrData, bus.TX_P_DATA} !== 27'h0) begin
      errors++;
      $display("FAIL mid_reset outputs nonzero busy=%b code=%b",
               bus.ctrl_busy, bus.err_code);
    end
    rst = 1'b0;
    @(negedge clk);
    send_byte(8'h77, 2, s);
    settle();
    checks++;
    if (wr_q.size() != 0 || err_q.size() != 1 ||
        err_q[0].a !== 8'd1 || err_q[0].cyc != s + 1) begin
      errors++;
      $display("FAIL mid_frame got wr=%0d err=%0d exp wr=0 err=1 code=1",
               wr_q.size(), err_q.size());
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL strobe_overlap got %0d exp 0", viol);
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.RX_P_DATA    = 8'h00;
    bus.RX_D_VLD     = 1'b0;
    bus.TX_Busy      = 1'b0;
    bus.RdData       = 8'h00;
    bus.RdData_Valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i]   = 8'($urandom);
      exp_regs[i] = rf_mem[i];
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bad_opcode_range();
    test_backpressure();
    test_random_frames();
    test_timeouts();
    test_reset_midframe();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_cmd_ctrl.md
Name: reg_file_cmd_ctrl

Overview:
- Byte-oriented command controller that sequences the 16x8 configuration register file from the receive side of the serial link.
- Decodes write and read frames from the RX parallel byte stream and issues single-cycle WrEn/RdEn strobes to the register file.
- Captures read data and hands it to the TX side under a busy/valid handshake.
- Flags malformed, out-of-range and timed-out frames.

Parameters:
- DATA_W, 8, byte and register width
- ADDR_W, 4, register file address width
- DEPTH, 16, number of implemented registers; address bytes >= DEPTH are rejected
- WR_CMD, 8'hAA, write frame opcode
- RD_CMD, 8'hBB, read frame opcode
- FRAME_TO, 255, maximum idle cycles allowed between bytes of one frame
- RD_TO, 15, maximum cycles to wait for RdData_Valid after RdEn

Ports:
- CLK  in  1  system clock; all logic on its rising edge
- RST  in  1  synchronous active-high reset
- RX_P_DATA  in  DATA_W  received byte
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid
- RdData  in  DATA_W  register file read data
- RdData_Valid  in  1  register file read data valid
- TX_Busy  in  1  TX serializer busy
- WrEn  out  1  register file write strobe
- RdEn  out  1  register file read strobe
- Address  out  ADDR_W  register file address
- WrData  out  DATA_W  register file write data
- TX_P_DATA  out  DATA_W  byte to transmit
- TX_D_VLD  out  1  one-cycle transmit strobe
- ctrl_busy  out  1  high whenever state != IDLE
- err_vld  out  1  one-cycle error strobe
- err_code  out  2  01 bad opcode, 10 address out of range, 11 timeout; held until next error

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high and has priority over everything else. On reset: state=IDLE, all outputs 0, counters 0, err_code=00.
- IDLE: on RX_D_VLD, a byte equal to WR_CMD goes to WR_ADDR and a byte equal to RD_CMD goes to RD_ADDR. Any other byte pulses err_vld with code 01 and stays in IDLE.
- WR_ADDR: on RX_D_VLD, latch the address and go to WR_DATA. A byte >= DEPTH pulses error 10 and returns to IDLE.
- WR_DATA: on RX_D_VLD, drive WrEn=1 with Address and WrData for exactly one cycle (the cycle after the strobe), then go to IDLE. Write latency is therefore 1 cycle from the data byte strobe.
- RD_ADDR: on RX_D_VLD, range-check as in WR_ADDR. If valid, RdEn=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: when RdData_Valid=1, capture RdData and go to TX_WAIT. If RD_TO cycles elapse with no valid, pulse error 11 and go to IDLE.
- TX_WAIT: while TX_Busy=1, hold. When TX_Busy=0, drive TX_P_DATA with the captured byte and TX_D_VLD=1 for one cycle, then go to IDLE.
- WrEn and RdEn are never high in the same cycle. Each is high for at most one cycle per frame.
- Address and WrData hold their last values between strobes. TX_P_DATA holds its last value.
- Frame timeout: in WR_ADDR, WR_DATA and RD_ADDR, the idle counter increments every cycle without RX_D_VLD and clears on RX_D_VLD. When it reaches FRAME_TO, pulse error 11 and go to IDLE.
- RX_D_VLD in RD_WAIT or TX_WAIT: the byte is dropped and there is no error. The controller does not queue bytes.
- Only ADDR_W LSBs of the address byte drive Address. The range check uses the full byte.
- Reset mid-frame: the partial frame is discarded, no strobe is issued, and any pending TX byte is lost.
- err_vld and a valid-frame strobe never coincide. An error always returns the FSM to IDLE.

Test Plan:
1. Write frame: RX bytes AA,05,3C with 2-cycle gaps -> WrEn=1 for one cycle after the 3C strobe, Address=5, WrData=3C. Then RX BB,05 -> RdEn pulse. With RdData=3C and RdData_Valid=1 returned and TX_Busy=0 -> TX_D_VLD pulse with TX_P_DATA=3C.
2. Bad opcode and range: RX 12 -> err_vld, err_code=01, FSM stays IDLE. RX AA,10 -> err_code=10, no WrEn. A following AA,0F,FF frame writes reg 15 normally.
3. TX backpressure: read of reg 2 with TX_Busy=1 for 20 cycles -> TX_D_VLD stays 0 and ctrl_busy stays 1. TX_D_VLD rises in the cycle after TX_Busy falls. An RX byte 55 sent during the wait is ignored.
4. Timeouts: RX AA then silence for 255 cycles -> err_code=11 and return to IDLE. Read with RdData_Valid held low for 15 cycles after RdEn -> err_code=11 and no TX_D_VLD.
5. Reset mid-frame: RX AA,03, then RST=1 for one cycle, then RX 77 -> no WrEn. 77 is treated as an opcode and yields err_code=01. All outputs are 0 during reset.
